// File: rtl/cpu_datapath_core.sv
// cpu_datapath_core: program counter, instruction register, accumulator, general register
// and carry for the 3-bit-opcode accumulator CPU, plus ROM/RAM address and control pins.
module cpu_datapath_core #(
    parameter logic [12:0] PC_RESET = 13'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  fetch,
    input  logic        PC_en,
    input  logic        ac_ena,
    input  logic        write_r,
    input  logic        read_r,
    input  logic        ram_ena,
    input  logic        ram_write,
    input  logic        ram_read,
    input  logic        rom_ena,
    input  logic        rom_read,
    input  logic        ad_sel,
    input  logic [7:0]  rom_data,
    input  logic [7:0]  ram_rdata,
    output logic [2:0]  ins,
    output logic [12:0] mem_addr,
    output logic        rom_oe,
    output logic        ram_ce,
    output logic        ram_we,
    output logic        ram_oe,
    output logic [7:0]  ram_wdata,
    output logic [7:0]  acc,
    output logic        carry
);

    localparam logic [1:0] FETCH_HI = 2'b01;
    localparam logic [1:0] FETCH_LO = 2'b10;
    localparam logic [2:0] OP_PRE   = 3'b100;
    localparam logic [2:0] OP_ADD   = 3'b101;
    localparam logic [2:0] OP_LDM   = 3'b110;

    logic [12:0] pc_r;
    logic [15:0] ir_r;
    logic [7:0]  acc_r;
    logic [7:0]  r_r;
    logic        carry_r;

    logic        rom_oe_s;
    logic        ram_oe_s;
    logic        ir_hi_ld_s;
    logic        ir_lo_ld_s;
    logic [8:0]  sum_s;
    logic [7:0]  acc_nxt_s;
    logic [7:0]  r_nxt_s;
    logic        carry_nxt_s;

    assign rom_oe_s   = rom_ena & rom_read;
    assign ram_oe_s   = ram_ena & ram_read;
    // An operand cycle (ad_sel high) never disturbs IR, even when it reuses fetch==01.
    assign ir_hi_ld_s = (fetch == FETCH_HI) & rom_oe_s & ~ad_sel;
    assign ir_lo_ld_s = (fetch == FETCH_LO) & rom_oe_s & ~ad_sel;
    assign sum_s      = {1'b0, acc_r} + {1'b0, r_r};

    assign ins       = ir_r[15:13];
    assign mem_addr  = ad_sel ? ir_r[12:0] : pc_r;
    assign rom_oe    = rom_oe_s;
    assign ram_ce    = ram_ena;
    assign ram_we    = ram_ena & ram_write;
    assign ram_oe    = ram_oe_s;
    assign ram_wdata = acc_r;
    assign acc       = acc_r;
    assign carry     = carry_r;

    // Program counter: free-running 13-bit increment on PC_en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r <= PC_RESET;
        end else if (PC_en) begin
            pc_r <= pc_r + 13'd1;
        end
    end

    // Instruction register: high and low bytes latched from ROM during fetch cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ir_r <= 16'h0000;
        end else begin
            if (ir_hi_ld_s) begin
                ir_r[15:8] <= rom_data;
            end
            if (ir_lo_ld_s) begin
                ir_r[7:0] <= rom_data;
            end
        end
    end

    // Next ACC/R/carry, prioritising write_r loads over read_r arithmetic.
    always_comb begin
        acc_nxt_s   = acc_r;
        r_nxt_s     = r_r;
        carry_nxt_s = carry_r;
        if (ac_ena && write_r) begin
            if (ins != OP_LDM) begin
                acc_nxt_s = ram_oe_s ? ram_rdata : rom_data;
            end else begin
                r_nxt_s = acc_r;
            end
        end else if (ac_ena && read_r) begin
            case (ins)
                OP_PRE:  acc_nxt_s = r_r;
                OP_ADD:  {carry_nxt_s, acc_nxt_s} = sum_s;
                default: acc_nxt_s = acc_r;
            endcase
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    // Accumulator, general register and carry storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r   <= 8'h00;
            r_r     <= 8'h00;
            carry_r <= 1'b0;
        end else begin
            acc_r   <= acc_nxt_s;
            r_r     <= r_nxt_s;
            carry_r <= carry_nxt_s;
        end
    end

endmodule

// File: tb/tb_cpu_datapath_core.sv
// Directed plus randomized bench for cpu_datapath_core against an arithmetic reference model
// of PC, IR, ACC, R and carry, with behavioural ROM/RAM arrays.
module tb_cpu_datapath_core;

    logic        clk;
    logic        rst;
    logic [1:0]  fetch;
    logic        PC_en, ac_ena, write_r, read_r;
    logic        ram_ena, ram_write, ram_read, rom_ena, rom_read, ad_sel;
    logic [7:0]  rom_data, ram_rdata;
    logic [2:0]  ins;
    logic [12:0] mem_addr;
    logic        rom_oe, ram_ce, ram_we, ram_oe;
    logic [7:0]  ram_wdata, acc;
    logic        carry;

    logic [7:0] rom_mem [0:8191];
    logic [7:0] ram_mem [0:8191];

    int vectors = 0;
    int miscompares = 0;

    // Reference state, kept as plain integers.
    int m_pc, m_ir, m_acc, m_r, m_carry;
    int n_pc, n_ir, n_acc, n_r, n_carry;

    cpu_datapath_core #(.PC_RESET(13'h0000)) dut (
        .clk(clk), .rst(rst), .fetch(fetch), .PC_en(PC_en), .ac_ena(ac_ena),
        .write_r(write_r), .read_r(read_r), .ram_ena(ram_ena), .ram_write(ram_write),
        .ram_read(ram_read), .rom_ena(rom_ena), .rom_read(rom_read), .ad_sel(ad_sel),
        .rom_data(rom_data), .ram_rdata(ram_rdata), .ins(ins), .mem_addr(mem_addr),
        .rom_oe(rom_oe), .ram_ce(ram_ce), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_wdata(ram_wdata), .acc(acc), .carry(carry)
    );

    assign rom_data  = rom_mem[mem_addr];
    assign ram_rdata = ram_mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int addr;
        addr = ad_sel ? (m_ir % 8192) : m_pc;
        check({tag, ".mem_addr"}, 16'(mem_addr), 16'(addr));
        check({tag, ".ins"}, 16'(ins), 16'(m_ir / 8192));
        check({tag, ".acc"}, 16'(acc), 16'(m_acc));
        check({tag, ".carry"}, 16'(carry), 16'(m_carry));
        check({tag, ".ram_wdata"}, 16'(ram_wdata), 16'(m_acc));
        check({tag, ".rom_oe"}, 16'(rom_oe), 16'(rom_ena && rom_read));
        check({tag, ".ram_ce"}, 16'(ram_ce), 16'(ram_ena));
        check({tag, ".ram_we"}, 16'(ram_we), 16'(ram_ena && ram_write));
        check({tag, ".ram_oe"}, 16'(ram_oe), 16'(ram_ena && ram_read));
    endtask

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_acc = 0; m_r = 0; m_carry = 0;
    endtask

    // Next reference state from the current strobes, following the documented priority rules.
    task automatic model_next();
        int addr, op, rd, sum;
        addr = ad_sel ? (m_ir % 8192) : m_pc;
        op   = m_ir / 8192;
        rd   = (ram_ena && ram_read) ? int'(ram_mem[addr]) : int'(rom_mem[addr]);
        n_pc = PC_en ? (m_pc + 1) % 8192 : m_pc;
        n_ir = m_ir; n_acc = m_acc; n_r = m_r; n_carry = m_carry;
        if (!ad_sel && rom_ena && rom_read && fetch == 2'b01)
            n_ir = int'(rom_mem[addr]) * 256 + (m_ir % 256);
        if (!ad_sel && rom_ena && rom_read && fetch == 2'b10)
            n_ir = (m_ir / 256) * 256 + int'(rom_mem[addr]);
        if (ac_ena && write_r) begin
            if (op == 6) n_r = m_acc;
            else n_acc = rd;
        end else if (ac_ena && read_r) begin
            if (op == 4) n_acc = m_r;
            if (op == 5) begin
                sum = m_acc + m_r;
                n_acc = sum % 256;
                n_carry = (sum > 255) ? 1 : 0;
            end
        end
    endtask

    task automatic tick(input string tag);
        model_next();
        @(posedge clk);
        m_pc = n_pc; m_ir = n_ir; m_acc = n_acc; m_r = n_r; m_carry = n_carry;
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        fetch = 2'b00; PC_en = 1'b0; ac_ena = 1'b0; write_r = 1'b0; read_r = 1'b0;
        ram_ena = 1'b0; ram_write = 1'b0; ram_read = 1'b0;
        rom_ena = 1'b0; rom_read = 1'b0; ad_sel = 1'b0;
    endtask

    // Two-byte instruction fetch at the current PC: fetch01, PC_en, fetch10, fetch10+PC_en.
    task automatic do_fetch(input logic [7:0] hi, input logic [7:0] lo);
        rom_mem[m_pc] = hi;
        rom_mem[(m_pc + 1) % 8192] = lo;
        idle(); fetch = 2'b01; rom_ena = 1'b1; rom_read = 1'b1;
        tick("fetch_hi");
        check("ins_decode", 16'(ins), 16'(hi[7:5]));
        idle(); PC_en = 1'b1;
        tick("pc_inc");
        idle(); fetch = 2'b10; rom_ena = 1'b1; rom_read = 1'b1;
        tick("fetch_lo");
        PC_en = 1'b1;
        tick("fetch_lo_pc");
        idle();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        for (int i = 0; i < 8192; i++) begin
            rom_mem[i] = 8'($urandom);
            ram_mem[i] = 8'($urandom);
        end
        model_reset();
        #2;
        check_all("reset");
        rom_ena = 1'b1; rom_read = 1'b1; ram_ena = 1'b1; ram_write = 1'b1;
        #1;
        check_all("reset_strobes");
        idle();
        @(posedge clk); #1;
        rst = 1'b1;

        // LDA 0x0110
        ram_mem[13'h0110] = 8'h3C;
        do_fetch(8'h41, 8'h10);
        ad_sel = 1'b1; ram_ena = 1'b1; ram_read = 1'b1; write_r = 1'b1; ac_ena = 1'b1;
        #1;
        check("lda_addr", 16'(mem_addr), 16'h0110);
        tick("lda_exec");
        check("lda_acc", 16'(acc), 16'h003C);
        idle(); #1;
        check("lda_pc", 16'(mem_addr), 16'h0002);

        // LDO from ROM 0x0020 with fetch==01 held in the data cycle
        rom_mem[13'h0020] = 8'hA5;
        do_fetch(8'h20, 8'h20);
        ad_sel = 1'b1; fetch = 2'b01; rom_ena = 1'b1; rom_read = 1'b1;
        write_r = 1'b1; ac_ena = 1'b1;
        tick("ldo_exec");
        check("ldo_acc", 16'(acc), 16'h00A5);
        check("ldo_ins_kept", 16'(ins), 16'h0001);

        // STO to 0x0005
        do_fetch(8'h60, 8'h05);
        ad_sel = 1'b1; ram_ena = 1'b1; ram_write = 1'b1;
        #1;
        check("sto_we", 16'(ram_we), 16'h0001);
        check("sto_addr", 16'(mem_addr), 16'h0005);
        check("sto_wdata", 16'(ram_wdata), 16'h00A5);
        tick("sto_exec");
        idle(); #1;
        check("sto_we_off", 16'(ram_we), 16'h0000);

        // LDA 0xF0, LDM, LDA 0x20, ADD, PRE
        ram_mem[13'h0200] = 8'hF0;
        ram_mem[13'h0201] = 8'h20;
        do_fetch(8'h42, 8'h00);
        ad_sel = 1'b1; ram_ena = 1'b1; ram_read = 1'b1; write_r = 1'b1; ac_ena = 1'b1;
        tick("lda_f0");
        do_fetch(8'hC0, 8'h00);
        write_r = 1'b1; ac_ena = 1'b1;
        tick("ldm_exec");
        check("ldm_acc_kept", 16'(acc), 16'h00F0);
        do_fetch(8'h42, 8'h01);
        ad_sel = 1'b1; ram_ena = 1'b1; ram_read = 1'b1; write_r = 1'b1; ac_ena = 1'b1;
        tick("lda_20");
        do_fetch(8'hA0, 8'h00);
        read_r = 1'b1; ac_ena = 1'b1;
        tick("add_exec");
        check("add_acc", 16'(acc), 16'h0010);
        check("add_carry", 16'(carry), 16'h0001);
        do_fetch(8'h80, 8'h00);
        read_r = 1'b1; ac_ena = 1'b1;
        tick("pre_exec");
        check("pre_acc", 16'(acc), 16'h00F0);
        check("pre_carry", 16'(carry), 16'h0001);

        // Non-updates
        idle(); ac_ena = 1'b1;
        tick("ac_ena_alone");
        check("ac_ena_alone_acc", 16'(acc), 16'h00F0);
        idle(); write_r = 1'b1; ram_ena = 1'b1; ram_read = 1'b1;
        tick("write_r_alone");
        check("write_r_alone_acc", 16'(acc), 16'h00F0);
        idle(); fetch = 2'b01; ad_sel = 1'b1; rom_ena = 1'b1; rom_read = 1'b1;
        tick("fetch_adsel");
        check("fetch_adsel_ins", 16'(ins), 16'h0004);

        // Randomized strobes
        for (int i = 0; i < 400; i++) begin
            {fetch, PC_en, ac_ena, write_r, read_r, ram_ena, ram_write, ram_read,
             rom_ena, rom_read, ad_sel} = 13'($urandom);
            tick("random");
        end

        // PC wrap with simultaneous high-byte fetch
        idle(); PC_en = 1'b1;
        for (int i = 0; i < 8192 && m_pc != 8191; i++) tick("pc_walk");
        rom_mem[13'h1FFF] = 8'hE7;
        fetch = 2'b01; rom_ena = 1'b1; rom_read = 1'b1;
        tick("pc_wrap");
        check("wrap_pc", 16'(mem_addr), 16'h0000);
        check("wrap_ins", 16'(ins), 16'h0007);

        // Reach PC=0x0123, ACC=0x55, then reset mid-cycle
        ram_mem[13'h0300] = 8'h55;
        do_fetch(8'h43, 8'h00);
        ad_sel = 1'b1; ram_ena = 1'b1; ram_read = 1'b1; write_r = 1'b1; ac_ena = 1'b1;
        tick("lda_55");
        idle(); PC_en = 1'b1;
        for (int i = 0; i < 8192 && m_pc != 13'h0123; i++) tick("pc_walk2");
        idle(); #1;
        check("pre_rst_pc", 16'(mem_addr), 16'h0123);
        check("pre_rst_acc", 16'(acc), 16'h0055);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_pc", 16'(mem_addr), 16'h0000);
        check("rst_ins", 16'(ins), 16'h0000);
        check("rst_acc", 16'(acc), 16'h0000);
        check("rst_carry", 16'(carry), 16'h0000);
        @(posedge clk); #1;
        rst = 1'b1;
        tick("post_rst_idle1");
        tick("post_rst_idle2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
